// File: rtl/pcx_req_sched.sv
// Round-robin scheduler sharing one PCX request port between NREQ requesters.
// Tracks per-destination credits and issues CAS1/CAS2 atomic pairs back-to-back.
module pcx_req_sched #(
  parameter int NREQ   = 4,
  parameter int W      = 124,
  parameter int MAXCRD = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_vld,
  input  logic [NREQ-1:0] req_atom,
  input  logic [5*NREQ-1:0] req_dest,
  input  logic [W*NREQ-1:0] req_data,
  output logic [NREQ-1:0] req_ack,
  output logic [4:0]      spc_pcx_req_pq,
  output logic            spc_pcx_atom_pq,
  output logic [W-1:0]    spc_pcx_data_pa,
  input  logic [4:0]      pcx_spc_grant_px,
  output logic            crd_err,
  output logic            atom_err
);

  localparam int ND  = 5;
  localparam int CW  = $clog2(MAXCRD + 1);
  localparam int CW2 = CW + 2;
  localparam int PW  = $clog2(NREQ);

  typedef enum logic {IDLE, ATOM2} state_t;

  typedef struct packed {
    logic [4:0] dest;
    logic       atom;
  } pq_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [4:0]      own_dest, own_dest_n;
  logic [CW-1:0]   credit [ND];
  logic [CW-1:0]   crd_n  [ND];
  pq_t             pq_q, pq_n;
  logic [W-1:0]    d1_q, d1_n;
  logic [W-1:0]    data_pa_q;

  logic [NREQ-1:0] elig;
  logic [4:0]      di;
  logic [CW2-1:0]  av, nd;
  logic            win_vld;
  logic [PW-1:0]   win, cand;
  logic [NREQ-1:0] ack;
  logic [4:0]      dec_dest, refund;
  logic            dec2;
  logic            aerr_set, cerr_set;
  logic [CW2-1:0]  cs;

  always_comb begin
    elig = '0;
    di   = '0;
    av   = '0;
    nd   = '0;
    for (int i = 0; i < NREQ; i++) begin
      di = req_dest[5*i +: 5];
      av = '0;
      for (int d = 0; d < ND; d++)
        if (di[d]) av = av | {2'b00, credit[d]};
      nd = req_atom[i] ? CW2'(2) : CW2'(1);
      elig[i] = req_vld[i] && $onehot(di) && (av >= nd);
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    own_dest_n = own_dest;
    ack        = '0;
    pq_n       = '0;
    d1_n       = '0;
    dec_dest   = '0;
    dec2       = 1'b0;
    refund     = '0;
    aerr_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          ack[win]  = 1'b1;
          pq_n.dest = req_dest[5*int'(win) +: 5];
          pq_n.atom = req_atom[win];
          d1_n      = req_data[W*int'(win) +: W];
          dec_dest  = pq_n.dest;
          dec2      = pq_n.atom;
          ptr_n     = PW'((int'(win) + 1) % NREQ);
          if (pq_n.atom) begin
            state_n    = ATOM2;
            owner_n    = win;
            own_dest_n = pq_n.dest;
          end
        end
      end
      ATOM2: begin
        // second half rides on the credit reserved by the first
        state_n = IDLE;
        if (req_vld[owner]) begin
          ack[owner] = 1'b1;
          pq_n.dest  = own_dest;
          d1_n       = req_data[W*int'(owner) +: W];
        end else begin
          aerr_set = 1'b1;
          refund   = own_dest;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cerr_set = 1'b0;
    cs       = '0;
    for (int d = 0; d < ND; d++) begin
      cs = {2'b00, credit[d]} + CW2'(pcx_spc_grant_px[d]) + CW2'(refund[d]);
      if (dec_dest[d]) cs = cs - (dec2 ? CW2'(2) : CW2'(1));
      if (cs > CW2'(MAXCRD)) cs = CW2'(MAXCRD);
      crd_n[d] = cs[CW-1:0];
      if (pcx_spc_grant_px[d] && credit[d] == CW'(MAXCRD)) cerr_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      own_dest  <= '0;
      pq_q      <= '0;
      d1_q      <= '0;
      data_pa_q <= '0;
      crd_err   <= 1'b0;
      atom_err  <= 1'b0;
      for (int d = 0; d < ND; d++) credit[d] <= CW'(MAXCRD);
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      own_dest  <= own_dest_n;
      pq_q      <= pq_n;
      d1_q      <= d1_n;
      data_pa_q <= d1_q;
      crd_err   <= crd_err | cerr_set;
      atom_err  <= atom_err | aerr_set;
      for (int d = 0; d < ND; d++) credit[d] <= crd_n[d];
    end
  end

  assign req_ack         = rst ? '0 : ack;
  assign spc_pcx_req_pq  = pq_q.dest;
  assign spc_pcx_atom_pq = pq_q.atom;
  assign spc_pcx_data_pa = data_pa_q;

endmodule

// File: tb/tb_pcx_req_sched.sv
// Directed table-driven bench for pcx_req_sched.
// One row per clock; registered outputs reflect earlier rows.
module tb_pcx_req_sched;

  localparam int NREQ = 4;
  localparam int W    = 124;

  localparam logic [4:0] E0 = 5'b00001;
  localparam logic [4:0] E1 = 5'b00010;
  localparam logic [4:0] E2 = 5'b00100;
  localparam logic [4:0] E3 = 5'b01000;
  localparam logic [4:0] E4 = 5'b10000;
  localparam int N = -1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_vld, req_atom, req_ack;
  logic [5*NREQ-1:0] req_dest;
  logic [W*NREQ-1:0] req_data;
  logic [4:0]        req_pq, gnt;
  logic              atom_pq, crd_err, atom_err;
  logic [W-1:0]      data_pa;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  atom;
    logic [19:0] dest;
    logic [4:0]  gnt;
    logic [3:0]  ack;
    logic [4:0]  pq;
    logic        apq;
    int          dsrc;
    logic        cerr;
    logic        aerr;
  } vec_t;

  vec_t tbl[$];

  pcx_req_sched #(.NREQ(NREQ), .W(W), .MAXCRD(2)) dut (
    .clk(clk),
    .rst(rst),
    .req_vld(req_vld),
    .req_atom(req_atom),
    .req_dest(req_dest),
    .req_data(req_data),
    .req_ack(req_ack),
    .spc_pcx_req_pq(req_pq),
    .spc_pcx_atom_pq(atom_pq),
    .spc_pcx_data_pa(data_pa),
    .pcx_spc_grant_px(gnt),
    .crd_err(crd_err),
    .atom_err(atom_err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] dst(logic [4:0] a, logic [4:0] b,
                                      logic [4:0] c, logic [4:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [W-1:0] dat(int i);
    logic [W-1:0] x;
    x = '0;
    x[W-1] = 1'b1;
    x[W-2 -: 8] = 8'(i * 17 + 3);
    x[31:0] = 32'hC0DE0000 + 32'(i);
    return x;
  endfunction

  function automatic void add(logic r, logic [3:0] v, logic [3:0] a,
                              logic [19:0] d, logic [4:0] g, logic [3:0] k,
                              logic [4:0] p, logic ap, int ds,
                              logic ce, logic ae);
    vec_t x;
    x.rst = r; x.vld = v; x.atom = a; x.dest = d; x.gnt = g;
    x.ack = k; x.pq = p; x.apq = ap; x.dsrc = ds;
    x.cerr = ce; x.aerr = ae;
    tbl.push_back(x);
  endfunction

  task automatic chk(string nm, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %h want %h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input vec_t v, input int r);
    logic [W-1:0] ed;
    rst = v.rst; req_vld = v.vld; req_atom = v.atom;
    req_dest = v.dest; gnt = v.gnt;
    #2;
    ed = (v.dsrc < 0) ? '0 : dat(v.dsrc);
    chk($sformatf("row%0d_ack", r), W'(req_ack), W'(v.ack));
    chk($sformatf("row%0d_req_pq", r), W'(req_pq), W'(v.pq));
    chk($sformatf("row%0d_atom_pq", r), W'(atom_pq), W'(v.apq));
    chk($sformatf("row%0d_data_pa", r), data_pa, ed);
    chk($sformatf("row%0d_crd_err", r), W'(crd_err), W'(v.cerr));
    chk($sformatf("row%0d_atom_err", r), W'(atom_err), W'(v.aerr));
    step();
  endtask

  initial begin
    logic [19:0] STD, T3, T4, NH;
    int lat;
    STD = dst(E0, E1, E2, E3);
    T3  = dst(E0, E2, E2, E3);
    T4  = dst(E0, E1, E1, E3);
    NH  = dst(5'b00011, E1, E1, E3);

    // single issue and pipeline timing
    add(1, 4'hF, 0, STD, 0, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'h1, 0, STD, 0, 4'h1, 0, 0, N, 0, 0);
    add(0, 4'h0, 0, STD, 0, 4'h0, E0, 0, N, 0, 0);
    add(0, 4'h0, 0, STD, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 0, STD, 0, 4'h0, 0, 0, N, 0, 0);
    // rotation and credit exhaustion
    add(1, 4'h0, 0, STD, 0, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h1, 0, 0, N, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h2, E0, 0, N, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h4, E1, 0, 0, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h8, E2, 0, 1, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h1, E3, 0, 2, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h2, E0, 0, 3, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h4, E1, 0, 0, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h8, E2, 0, 1, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h0, E3, 0, 2, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h0, 0, 0, 3, 0, 0);
    add(0, 4'hF, 0, STD, 0, 4'h0, 0, 0, N, 0, 0);
    // grant return, grant with issue
    add(1, 4'h0, 0, T3, 0, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'h2, 0, T3, 0, 4'h2, 0, 0, N, 0, 0);
    add(0, 4'h2, 0, T3, 0, 4'h2, E2, 0, N, 0, 0);
    add(0, 4'h2, 0, T3, 0, 4'h0, E2, 0, 1, 0, 0);
    add(0, 4'h2, 0, T3, E2, 4'h0, 0, 0, 1, 0, 0);
    add(0, 4'h2, 0, T3, 0, 4'h2, 0, 0, N, 0, 0);
    add(0, 4'h2, 0, T3, E2, 4'h0, E2, 0, N, 0, 0);
    add(0, 4'h2, 0, T3, E2, 4'h2, 0, 0, 1, 0, 0);
    add(0, 4'h2, 0, T3, 0, 4'h2, E2, 0, N, 0, 0);
    add(0, 4'h2, 0, T3, 0, 4'h0, E2, 0, 1, 0, 0);
    add(0, 4'h0, 0, T3, 0, 4'h0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 0, T3, 0, 4'h0, 0, 0, N, 0, 0);
    // atomic pair holds off requester 3
    add(1, 4'h0, 0, T4, 0, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'hC, 4'h4, T4, 0, 4'h4, 0, 0, N, 0, 0);
    add(0, 4'hC, 4'h0, T4, 0, 4'h4, E1, 1, N, 0, 0);
    add(0, 4'h8, 4'h0, T4, 0, 4'h8, E1, 0, 2, 0, 0);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, E3, 0, 2, 0, 0);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, 3, 0, 0);
    add(0, 4'h4, 4'h0, T4, 0, 4'h0, 0, 0, N, 0, 0);
    // atomic needs two credits; dropped second half
    add(0, 4'h0, 4'h0, T4, E1, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'h4, 4'h4, T4, 0, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'h4, 4'h4, T4, E1, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'h4, 4'h4, T4, 0, 4'h4, 0, 0, N, 0, 0);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, E1, 1, N, 0, 0);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, 2, 0, 1);
    add(0, 4'h4, 4'h0, T4, 0, 4'h4, 0, 0, N, 0, 1);
    add(0, 4'h4, 4'h0, T4, 0, 4'h0, E1, 0, N, 0, 1);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, 2, 0, 1);
    add(0, 4'h1, 4'h0, NH, 0, 4'h0, 0, 0, N, 0, 1);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, N, 0, 1);
    // grant at full credit; reset mid-pair
    add(0, 4'h0, 4'h0, T4, E4, 4'h0, 0, 0, N, 0, 1);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, N, 1, 1);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, N, 1, 1);
    add(0, 4'h1, 4'h1, T4, 0, 4'h1, 0, 0, N, 1, 1);
    add(1, 4'h1, 4'h0, T4, 0, 4'h0, E0, 1, N, 1, 1);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, N, 0, 0);
    add(0, 4'h1, 4'h1, T4, 0, 4'h1, 0, 0, N, 0, 0);
    add(0, 4'h1, 4'h0, T4, 0, 4'h1, E0, 1, N, 0, 0);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, E0, 0, 0, 0, 0);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 4'h0, T4, 0, 4'h0, 0, 0, N, 0, 0);

    for (int i = 0; i < NREQ; i++) req_data[W*i +: W] = dat(i);
    rst = 1'b1; req_vld = '0; req_atom = '0; req_dest = STD; gnt = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[r]) run_row(tbl[r], r);

    // grant-to-ack latency with a bounded wait
    rst = 1'b1; req_vld = '0; req_atom = '0; req_dest = STD; gnt = '0;
    step();
    rst = 1'b0;
    req_vld = 4'h1;
    #2 chk("seq_ack1", W'(req_ack), W'(4'h1));
    step();
    #2 chk("seq_ack2", W'(req_ack), W'(4'h1));
    step();
    #2 chk("seq_stall", W'(req_ack), W'(4'h0));
    step();
    gnt = E0;
    #2 chk("seq_grant_cycle", W'(req_ack), W'(4'h0));
    step();
    gnt = '0;
    lat = -1;
    for (int c = 1; c <= 4 && lat < 0; c++) begin
      #2;
      if (req_ack[0]) lat = c;
      step();
    end
    req_vld = '0;
    chk("seq_grant_to_ack", W'(lat), W'(1));
    #2 chk("seq_pq", W'(req_pq), W'(E0));
    step();
    #2 chk("seq_data", data_pa, dat(0));
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
